div_unit: RTL and testbench

//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_unit_if.sv | 28 ++
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 160 ++++++++++++++++
 tb/tb_div_unit.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned ITER_COUNT = DATA_WIDTH;

    // Encoding matches funct3[1:0]
    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix,
        StDone
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [ADDR_WIDTH-1:0] rd_in;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] rd_out;
    logic                  busy;

    modport master (
        output in_valid, op, a, b, rd_in, flush, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  in_valid, op, a, b, rd_in, flush, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] quo_i,
    input  logic [Width-1:0] div_i,
    output logic [Width-1:0] rem_o,
    output logic [Width-1:0] quo_o
);
    logic [Width:0]   shifted;
    logic [Width+1:0] trial;
    logic             unused_trial_msb;

    assign shifted = {rem_i, quo_i[Width-1]};
    assign trial   = {1'b0, shifted} - {2'b00, div_i};
    // A successful subtraction always leaves a value below the divisor
    assign unused_trial_msb = trial[Width];

    always_comb begin
        if (trial[Width+1]) begin
            rem_o = shifted[Width-1:0];
            quo_o = {quo_i[Width-2:0], 1'b0};
        end else begin
            rem_o = trial[Width-1:0];
            quo_o = {quo_i[Width-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and overflow go straight to DONE.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = div_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = div_pkg::ADDR_WIDTH
) (
    input logic       clk_i,
    input logic       rst_i,
    div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(ITER_COUNT);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] special_res_q, special_res_d, result_q, result_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic                  is_rem_q, is_rem_d, special_q, special_d;

    div_op_e               op;
    logic                  signed_op, is_rem, a_neg, b_neg, div_zero, overflow, accept;
    logic [DATA_WIDTH-1:0] a_abs, b_abs, special_res, step_rem, step_quo;
    logic [DATA_WIDTH-1:0] quo_fix, rem_fix, fix_res;

    assign op        = div_op_e'(bus.op);
    assign signed_op = (op == OpDiv) || (op == OpRem);
    assign is_rem    = (op == OpRem) || (op == OpRemu);
    assign a_neg     = signed_op & bus.a[DATA_WIDTH-1];
    assign b_neg     = signed_op & bus.b[DATA_WIDTH-1];
    // Two's-complement negate; the most negative value maps onto its own unsigned magnitude
    assign a_abs     = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_abs     = b_neg ? (~bus.b + 1'b1) : bus.b;

    assign div_zero  = (bus.b == '0);
    assign overflow  = signed_op && (bus.a == MinNeg) && (bus.b == '1);
    always_comb begin
        special_res = is_rem ? '0 : MinNeg;
        if (div_zero) begin
            special_res = is_rem ? bus.a : '1;
        end
    end

    assign accept = (state_q == StIdle) && bus.in_valid && !bus.flush;

    div_step #(
        .Width (DATA_WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    assign fix_res = special_q ? special_res_q : (is_rem_q ? rem_fix : quo_fix);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        special_res_d = special_res_q;
        result_d      = result_q;
        rd_d          = rd_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        is_rem_d      = is_rem_q;
        special_d     = special_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d       = StIter;
                    cnt_d         = CntW'(ITER_COUNT - 1);
                    rem_d         = '0;
                    quo_d         = a_abs;
                    dvs_d         = b_abs;
                    neg_quo_d     = a_neg ^ b_neg;
                    neg_rem_d     = a_neg;
                    is_rem_d      = is_rem;
                    special_d     = div_zero | overflow;
                    special_res_d = special_res;
                    rd_d          = bus.rd_in;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero | overflow) begin
                        state_d  = StDone;
                        result_d = special_res;
                    end
`endif
                end
            end
            StIter: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = fix_res;
                state_d  = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any handshake in the same cycle
        if (bus.flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            special_res_q <= '0;
            result_q      <= '0;
            rd_q          <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            is_rem_q      <= 1'b0;
            special_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            special_res_q <= special_res_d;
            result_q      <= result_d;
            rd_q          <= rd_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            is_rem_q      <= is_rem_d;
            special_q     <= special_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; expected latency follows DIV_EARLY_OUT_EN.
module tb_div_unit;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int SpecLat = 1;
`else
    localparam int SpecLat = 34;
`endif
    localparam int NormLat = 34;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    div_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    div_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.rd_in    = rd;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 32'h0;
        bus.b        = 32'h0;
        bus.rd_in    = 5'd0;
    endtask

    // Returns cycles from accept to out_valid, or -1 on timeout
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output int lat);
        issue(op, a, b, rd);
        wait_valid(lat);
        res = bus.result;
        handshake();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.result !== 32'h0 || bus.rd_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%0d want 0/0", bus.result, bus.rd_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu();
        int lat;
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL divu_busy: got ready %b busy %b want 0 1", bus.in_ready, bus.busy);
        end
        // A request while busy must be ignored
        bus.op = 2'b01; bus.a = 32'd50; bus.b = 32'd5; bus.rd_in = 5'd9; bus.in_valid = 1'b1;
        wait_valid(lat);
        bus.in_valid = 1'b0;
        n_checks++;
        if (lat !== NormLat) begin
            n_fail++; $display("FAIL divu_latency: got %0d want %0d", lat, NormLat);
        end
        n_checks++;
        if (bus.result !== 32'd14) begin
            n_fail++; $display("FAIL divu_result: got %h want %h", bus.result, 32'd14);
        end
        n_checks++;
        if (bus.rd_out !== 5'd5) begin
            n_fail++; $display("FAIL divu_rd: got %0d want 5", bus.rd_out);
        end
        handshake();
    endtask

    task automatic test_signed();
        logic [31:0] res;
        int lat;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1, res, lat);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL rem_neg: got %h want ffffffff", res);
        end
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, res, lat);
        n_checks++;
        if (res !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL div_neg: got %h want fffffffd", res);
        end
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd1, res, lat);
        n_checks++;
        if (res !== 32'h7FFF_FFFC) begin
            n_fail++; $display("FAIL divu_big: got %h want 7ffffffc", res);
        end
        run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd1, res, lat);
        n_checks++;
        if (res !== 32'hFFFF_FFF2) begin
            n_fail++; $display("FAIL div_neg_divisor: got %h want fffffff2", res);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        int lat;
        run_op(2'b00, 32'd5, 32'd0, 5'd3, res, lat);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL div_zero_q: got %h want ffffffff", res);
        end
        n_checks++;
        if (lat !== SpecLat) begin
            n_fail++; $display("FAIL div_zero_latency: got %0d want %0d", lat, SpecLat);
        end
        run_op(2'b11, 32'd5, 32'd0, 5'd3, res, lat);
        n_checks++;
        if (res !== 32'd5) begin
            n_fail++; $display("FAIL remu_zero: got %h want 5", res);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd3, res, lat);
        n_checks++;
        if (res !== 32'hFFFF_FFF9) begin
            n_fail++; $display("FAIL rem_zero_neg: got %h want fffffff9", res);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] res;
        int lat;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, res, lat);
        n_checks++;
        if (res !== 32'h8000_0000) begin
            n_fail++; $display("FAIL ovf_div: got %h want 80000000", res);
        end
        n_checks++;
        if (lat !== SpecLat) begin
            n_fail++; $display("FAIL ovf_latency: got %0d want %0d", lat, SpecLat);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, res, lat);
        n_checks++;
        if (res !== 32'h0) begin
            n_fail++; $display("FAIL ovf_rem: got %h want 0", res);
        end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, res, lat);
        n_checks++;
        if (res !== 32'h8000_0000 || lat !== NormLat) begin
            n_fail++; $display("FAIL remu_min: got %h lat %0d want 80000000 lat %0d",
                               res, lat, NormLat);
        end
        run_op(2'b00, 32'h8000_0000, 32'd2, 5'd4, res, lat);
        n_checks++;
        if (res !== 32'hC000_0000) begin
            n_fail++; $display("FAIL div_min_by_2: got %h want c0000000", res);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        int seen = 0;
        issue(2'b01, 32'd1000, 32'd3, 5'd7);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: got ready %b valid %b want 1 0",
                               bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen);
        end
        run_op(2'b01, 32'd9, 32'd3, 5'd8, res, lat);
        n_checks++;
        if (res !== 32'd3 || lat !== NormLat) begin
            n_fail++; $display("FAIL flush_next_op: got %h lat %0d want 3 lat %0d",
                               res, lat, NormLat);
        end
    endtask

    task automatic test_stall();
        int lat;
        int bad = 0;
        issue(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd17);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.result !== 32'hFFFF_FFF2 || bus.rd_out !== 5'd17) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0 (res %h rd %0d)",
                               bad, bus.result, bus.rd_out);
        end
        handshake();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got ready %b valid %b want 1 0",
                               bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        run_op(2'b11, 32'd100, 32'd7, 5'd2, res, lat);
        n_checks++;
        if (res !== 32'd2 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got %h ready %b want 2 ready 1",
                               res, bus.in_ready);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'd16, 5'd30, res, lat);
        n_checks++;
        if (res !== 32'h0FFF_FFFF || lat !== NormLat) begin
            n_fail++; $display("FAIL b2b_second: got %h lat %0d want 0fffffff lat %0d",
                               res, lat, NormLat);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(2'b01, 32'd77, 32'd5, 5'd12);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.result !== 32'h0 || bus.rd_out !== 5'd0) begin
            n_fail++; $display("FAIL reset_mid_op: got ready %b valid %b res %h rd %0d want 1 0 0 0",
                               bus.in_ready, bus.out_valid, bus.result, bus.rd_out);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.rd_in     = 5'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
